// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snn_pkg
//  Purpose  : Shared constants and the AER event type used by the LIF array,
//             the spike AER encoder and the downstream spike router.
//  Contents : N_NEURONS, ADDR_W, TS_W, FIFO_DEPTH, aer_event_t,
//             lowest_set() priority encoder, is_onehot() helper.
//  Revision : 1.0  initial release
// ============================================================================
package snn_pkg;

    localparam int N_NEURONS  = 4;
    localparam int ADDR_W     = 2;
    localparam int TS_W       = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } aer_event_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    // Scanning from the top down lets the lowest index win.
    function automatic logic [ADDR_W-1:0] lowest_set(input logic [N_NEURONS-1:0] v);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (v[i]) idx = ADDR_W'(i);
        end
        return idx;
    endfunction

    // True iff exactly one bit is set.
    function automatic logic is_onehot(input logic [N_NEURONS-1:0] v);
        return (v != '0) && ((v & (v - N_NEURONS'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : spike_fifo
//  Purpose  : Synchronous FIFO holding timestamped spike vectors.
//  Ports    : clk, rst      clock / synchronous active-high reset
//             push_i        write wdata_i (caller guarantees room or pop)
//             pop_i         advance read pointer (caller guarantees !empty)
//             wdata_i       entry to write
//             rdata_o       head entry (combinational read of head slot)
//             full_o        registered, count == DEPTH
//             count_o       number of stored entries
//  Revision : 1.0  initial release
// ============================================================================
module spike_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap mod DEPTH for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset: contents are only observed behind count_q.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_aer_encoder
//  Purpose  : Timestamps the LIF spike vector, buffers it and serializes it
//             into AER events {ts, addr, last} on a valid/ready interface.
//  Ports    : clk, rst      clock / synchronous active-high reset
//             en            sample enable, also advances the timestamp
//             spike_in      spike vector, bit i = neuron i
//             ev_ready      downstream accepts event
//             ev_valid/ev_addr/ev_ts/ev_last   event output
//             fifo_full     buffer full (registered)
//             drop_cnt      saturating count of dropped vectors
//  Revision : 1.0  initial release
// ============================================================================
module spike_aer_encoder
    import snn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 ev_ready,
    output logic                 ev_valid,
    output logic [ADDR_W-1:0]    ev_addr,
    output logic [TS_W-1:0]      ev_ts,
    output logic                 ev_last,
    output logic                 fifo_full,
    output logic [7:0]           drop_cnt
);

    localparam int FW = TS_W + N_NEURONS;

    logic [TS_W-1:0]         ts_q;
    logic [N_NEURONS-1:0]    p_q, p_d;
    logic [TS_W-1:0]         pts_q, pts_d;
    logic [7:0]              drop_q;

    logic [FW-1:0]           w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                    w_full, w_empty;
    logic                    w_push_req, w_push, w_pop, w_drop, w_fire;
    aer_event_t              w_ev;

    // All outputs decode directly from registers (P, its ts) so they stay
    // stable until the event is fired.
    assign w_ev.ts   = pts_q;
    assign w_ev.addr = lowest_set(p_q);
    assign w_ev.last = is_onehot(p_q);

    assign ev_valid  = (p_q != '0);
    assign ev_addr   = w_ev.addr;
    assign ev_ts     = w_ev.ts;
    assign ev_last   = w_ev.last;
    assign fifo_full = w_full;
    assign drop_cnt  = drop_q;

    assign w_empty    = (w_count == '0);
    assign w_fire     = ev_valid & ev_ready;
    assign w_pop      = !w_empty && ((p_q == '0) || (w_fire && w_ev.last));
    assign w_push_req = en && (spike_in != '0);
    // A full buffer still accepts when the head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    spike_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i ({ts_q, spike_in}),
        .rdata_o (w_head),
        .full_o  (w_full),
        .count_o (w_count)
    );

    // Serializer next state: a pop reloads P directly so consecutive vectors
    // stream without a bubble; otherwise a fire clears the bit just sent.
    always_comb begin
        p_d   = p_q;
        pts_d = pts_q;
        if (w_pop) begin
            p_d   = w_head[N_NEURONS-1:0];
            pts_d = w_head[FW-1:N_NEURONS];
        end else if (w_fire) begin
            p_d = p_q & ~(N_NEURONS'(1) << w_ev.addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q   <= '0;
            p_q    <= '0;
            pts_q  <= '0;
            drop_q <= '0;
        end else begin
            if (en) ts_q <= ts_q + TS_W'(1);
            p_q   <= p_d;
            pts_q <= pts_d;
            if (w_drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spike_aer_encoder
//  Purpose  : Self-checking bench for spike_aer_encoder. Expected events are
//             queued when a spike vector is driven and compared as the DUT
//             presents them; output stability under backpressure is checked
//             every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spike_aer_encoder;
    import snn_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [N_NEURONS-1:0] spike_in;
    logic                 ev_ready;
    logic                 ev_valid;
    logic [ADDR_W-1:0]    ev_addr;
    logic [TS_W-1:0]      ev_ts;
    logic                 ev_last;
    logic                 fifo_full;
    logic [7:0]           drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    aer_event_t sb[$];
    logic [TS_W-1:0] ts_m;

    always #5 clk = ~clk;

    spike_aer_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .spike_in  (spike_in),
        .ev_ready  (ev_ready),
        .ev_valid  (ev_valid),
        .ev_addr   (ev_addr),
        .ev_ts     (ev_ts),
        .ev_last   (ev_last),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference timestamp: counts enabled edges since reset.
    always @(posedge clk) begin
        if (rst)     ts_m <= '0;
        else if (en) ts_m <= ts_m + 8'd1;
    end

    // Monitor: consume expected events and check stability while stalled.
    logic            hold_v = 1'b0;
    aer_event_t      hold_e;
    always @(negedge clk) begin
        aer_event_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", ev_valid, 1);
                check("hold_addr",  ev_addr,  hold_e.addr);
                check("hold_ts",    ev_ts,    hold_e.ts);
                check("hold_last",  ev_last,  hold_e.last);
            end
            if (ev_valid && ev_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ev_addr", ev_addr, e.addr);
                    check("ev_ts",   ev_ts,   e.ts);
                    check("ev_last", ev_last, e.last);
                end
            end
            hold_v      = ev_valid && !ev_ready;
            hold_e.addr = ev_addr;
            hold_e.ts   = ev_ts;
            hold_e.last = ev_last;
        end
    end

    // Called just after a posedge; the vector is captured on the next edge.
    task automatic drive(input logic [N_NEURONS-1:0] v, input bit exp_drop);
        aer_event_t e;
        logic [N_NEURONS-1:0] rest;
        spike_in = v;
        en       = 1'b1;
        if (!exp_drop) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (v[i]) begin
                    rest   = v >> (i + 1);
                    e.ts   = ts_m;
                    e.addr = ADDR_W'(i);
                    e.last = (rest == '0);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
        spike_in = '0;
    endtask

    task automatic idle(input int n, input logic en_v);
        spike_in = '0;
        en       = en_v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input int budget);
        int cyc = 0;
        en = 1'b0;
        while (sb.size() != 0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_remaining", sb.size(), 0);
        idle(3, 1'b0);
        check("idle_valid", ev_valid, 0);
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with spikes present
        rst = 1'b1; en = 1'b1; spike_in = 4'b1111; ev_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ev_valid, 0);
        check("rst_addr",  ev_addr,  0);
        check("rst_ts",    ev_ts,    0);
        check("rst_last",  ev_last,  0);
        check("rst_full",  fifo_full, 0);
        check("rst_drop",  drop_cnt, 0);
        spike_in = '0; en = 1'b0; rst = 1'b0;

        // 2: single spike at ts=5, two-cycle latency
        idle(5, 1'b1);
        drive(4'b0100, 1'b0);
        en = 1'b0;
        check("lat_edge_k", ev_valid, 0);
        @(posedge clk); #1;
        check("lat_edge_k1", ev_valid, 1);
        wait_drain(20);

        // 3: multi-bit vector at ts=3, one event per cycle
        pulse_reset();
        idle(3, 1'b1);
        drive(4'b1011, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("burst_valid", ev_valid, (i < 3) ? 1 : 0);
        end
        wait_drain(20);

        // 4: backpressure, sixth vector dropped
        ev_ready = 1'b0;
        for (int i = 1; i <= 6; i++) drive(N_NEURONS'(i), (i == 6));
        idle(4, 1'b0);
        check("bp_full", fifo_full, 1);
        check("bp_drop", drop_cnt, 1);
        ev_ready = 1'b1;
        wait_drain(100);
        check("bp_full_after", fifo_full, 0);

        // 5: timestamp wrap
        spike_in = '0; en = 1'b1;
        for (int i = 0; i < 300 && ts_m != 8'd254; i++) begin @(posedge clk); #1; end
        check("wrap_reach", ts_m, 254);
        idle(1, 1'b1);
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        wait_drain(20);

        // 6: reset mid-stream with P=1110 and two FIFO entries
        ev_ready = 1'b0;
        drive(4'b1110, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        en = 1'b0;
        check("mid_valid", ev_valid, 1);
        check("mid_addr",  ev_addr,  1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check("mid_rst_valid", ev_valid, 0);
        check("mid_rst_full",  fifo_full, 0);
        rst = 1'b0;
        ev_ready = 1'b1;
        idle(10, 1'b0);
        check("mid_post_valid", ev_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
